// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and helpers for the multiport register file
//
// Holds the clear/ready state encoding, the storage depth computation and the
// write-port priority resolver used by both the storage update and the read
// bypass, so the two paths can never disagree on which port wins.

package rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  // Upper bound on write ports; narrower configurations pad unused lanes.
  localparam int RF_MAX_WRITE_PORTS = 2;

  typedef struct packed {
    logic       hit;
    logic [0:0] idx;
  } rf_wsel_t;

  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Highest matching port index wins, matching program order within a cycle.
  function automatic rf_wsel_t rf_resolve_write(input logic [RF_MAX_WRITE_PORTS-1:0] match);
    rf_wsel_t sel;
    sel.hit = 1'b0;
    sel.idx = 1'b0;
    for (int i = 0; i < RF_MAX_WRITE_PORTS; i++) begin
      if (match[i]) begin
        sel.hit = 1'b1;
        sel.idx = i[0:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending (outstanding producer) tracker
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ready_i               register file is out of CLEAR; reserves accepted
//   wr_accept_i[w]        write lane w is committing this cycle
//   wr_addr_i[w]          write lane w target register
//   reserve_i             set pending for reserve_address_i
//   reserve_address_i     register being reserved
//   read_address_i[p]     read port lookup address
//   read_write_hit_i[p]   a committing write targets read_address_i[p]
//   read_pending_o[p]     pending bit of read_address_i[p]

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 3,
  parameter bit BYPASS_EN      = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ready_i,
  input  logic [RF_MAX_WRITE_PORTS-1:0] wr_accept_i,
  input  logic [REG_ADDR_WIDTH-1:0]     wr_addr_i [RF_MAX_WRITE_PORTS],
  input  logic                          reserve_i,
  input  logic [REG_ADDR_WIDTH-1:0]     reserve_address_i,
  input  logic [REG_ADDR_WIDTH-1:0]     read_address_i [NUM_READ_PORTS],
  input  logic [NUM_READ_PORTS-1:0]     read_write_hit_i,
  output logic [NUM_READ_PORTS-1:0]     read_pending_o
);

  localparam int DEPTH = rf_depth(REG_ADDR_WIDTH);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int w = 0; w < RF_MAX_WRITE_PORTS; w++) begin
      if (wr_accept_i[w]) begin
        pending_d[wr_addr_i[w]] = 1'b0;
      end
    end
    // Applied after the clears: a reserve issued alongside a completing write
    // belongs to a newer producer, so the bit must stay set.
    if (ready_i && reserve_i && (reserve_address_i != '0)) begin
      pending_d[reserve_address_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // With bypass the reader already sees the completing write's data, so the
  // register is no longer waiting from its point of view.
  always_comb begin
    read_pending_o = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      read_pending_o[p] = ready_i && pending_q[read_address_i[p]]
                          && !(BYPASS_EN && read_write_hit_i[p]);
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-read, multi-write register file with bypass and scoreboard
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   write_enable_i[w]     write strobe per write port
//   write_address_i[w]    write target register (x0 writes discarded)
//   write_data_i[w]       write data
//   read_address_i[p]     asynchronous read address
//   read_data_o[p]        read data (combinational, bypassed when enabled)
//   read_pending_o[p]     addressed register has an outstanding producer
//   reserve_i             mark reserve_address_i pending
//   reserve_address_i     register to reserve
//   ready_o               storage cleared; writes and reserves accepted

module multiport_register_file
  import rf_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int NUM_READ_PORTS  = 3,
  parameter int NUM_WRITE_PORTS = 2,
  parameter bit BYPASS_EN       = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_WRITE_PORTS-1:0] write_enable_i,
  input  logic [REG_ADDR_WIDTH-1:0]  write_address_i [NUM_WRITE_PORTS],
  input  logic [XLEN-1:0]            write_data_i [NUM_WRITE_PORTS],
  input  logic [REG_ADDR_WIDTH-1:0]  read_address_i [NUM_READ_PORTS],
  output logic [XLEN-1:0]            read_data_o [NUM_READ_PORTS],
  output logic [NUM_READ_PORTS-1:0]  read_pending_o,
  input  logic                       reserve_i,
  input  logic [REG_ADDR_WIDTH-1:0]  reserve_address_i,
  output logic                       ready_o
);

  localparam int DEPTH = rf_depth(REG_ADDR_WIDTH);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  rf_state_e       state_q, state_d;
  addr_t           clr_ptr_q, clr_ptr_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [DEPTH];
  logic [XLEN-1:0] regs_d [DEPTH];

  // Write lanes padded to the package maximum so the shared resolver sees a
  // fixed-width match vector regardless of NUM_WRITE_PORTS.
  logic [RF_MAX_WRITE_PORTS-1:0] wacc_pad;
  addr_t                         waddr_pad [RF_MAX_WRITE_PORTS];
  logic [XLEN-1:0]               wdata_pad [RF_MAX_WRITE_PORTS];

  logic [NUM_READ_PORTS-1:0]     rd_hit;

  for (genvar w = 0; w < RF_MAX_WRITE_PORTS; w++) begin : g_wpad
    if (w < NUM_WRITE_PORTS) begin : g_used
      assign wacc_pad[w]  = (state_q == RF_READY) && write_enable_i[w]
                            && (write_address_i[w] != '0);
      assign waddr_pad[w] = write_address_i[w];
      assign wdata_pad[w] = write_data_i[w];
    end else begin : g_unused
      assign wacc_pad[w]  = 1'b0;
      assign waddr_pad[w] = '0;
      assign wdata_pad[w] = '0;
    end
  end

  function automatic logic [RF_MAX_WRITE_PORTS-1:0] write_match(input addr_t addr);
    logic [RF_MAX_WRITE_PORTS-1:0] m;
    m = '0;
    for (int w = 0; w < RF_MAX_WRITE_PORTS; w++) begin
      m[w] = wacc_pad[w] && (waddr_pad[w] == addr);
    end
    return m;
  endfunction

  // Clear engine: walks x1..x(DEPTH-1) once per reset, one entry per edge.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RF_CLEAR) begin
      clr_ptr_d = clr_ptr_q + addr_t'(1);
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = RF_READY;
      end
    end
    ready_d = (state_d == RF_READY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= addr_t'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign ready_o = ready_q;

  // Storage is left unreset so it can map onto distributed RAM; the clear
  // engine provides the zero initial state instead.
  always_comb begin
    rf_wsel_t sel;
    sel    = '0;
    regs_d = regs_q;
    if (state_q == RF_CLEAR) begin
      regs_d[clr_ptr_q] = '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        sel = rf_resolve_write(write_match(addr_t'(r)));
        if (sel.hit) begin
          regs_d[r] = wdata_pad[sel.idx];
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rf_wsel_t sel;
    sel    = '0;
    rd_hit = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      sel       = rf_resolve_write(write_match(read_address_i[p]));
      rd_hit[p] = sel.hit;
      if ((state_q != RF_READY) || (read_address_i[p] == '0)) begin
        read_data_o[p] = '0;
      end else if (BYPASS_EN && sel.hit) begin
        read_data_o[p] = wdata_pad[sel.idx];
      end else begin
        read_data_o[p] = regs_q[read_address_i[p]];
      end
    end
  end

  rf_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .BYPASS_EN      (BYPASS_EN)
  ) u_scoreboard (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ready_i           (state_q == RF_READY),
    .wr_accept_i       (wacc_pad),
    .wr_addr_i         (waddr_pad),
    .reserve_i         (reserve_i),
    .reserve_address_i (reserve_address_i),
    .read_address_i    (read_address_i),
    .read_write_hit_i  (rd_hit),
    .read_pending_o    (read_pending_o)
  );

endmodule
